// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the sequential ALU (seq_alu) and its
// iterative multiplier (alu_mul_seq).
//   ALU_OP_W : width of the operation code
//   alu_op_e : operation encodings ALU_ADD .. ALU_MUL (1001-1111 are illegal)
//   state_e  : handshake FSM states S_IDLE, S_BUSY, S_DONE
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_NOT = 4'b0010,
        ALU_AND = 4'b0011,
        ALU_OR  = 4'b0100,
        ALU_XOR = 4'b0101,
        ALU_SLT = 4'b0110,
        ALU_EQ  = 4'b0111,
        ALU_MUL = 4'b1000
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Shift-add multiplier producing the low WIDTH bits of a*b, one multiplier
// bit per cycle. Only instantiated when ALU_MUL_EN is defined.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse; a and b are captured on this edge
//   a, b       : operands (sampled with start)
//   done       : high during the last of the WIDTH step cycles
//   product    : final product, valid while done is high
// -----------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic [WIDTH-1:0] step_s;
    logic             last_s;

    // Partial product after the current step; on the last step this is the
    // answer, so it is exposed directly and the caller can capture it at once.
    always_comb begin
        step_s = acc_r;
        if (mplier_r[0]) begin
            step_s = acc_r + mcand_r;
        end else begin
            step_s = acc_r;
        end
    end

    assign last_s  = busy_r & (cnt_r == CNT_LAST);
    assign done    = last_s;
    assign product = step_s;

    // Operand capture and one shift-add step per cycle while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
        end else if (start) begin
            mcand_r  <= a;
            mplier_r <= b;
            acc_r    <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= step_s;
            mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            if (last_s) begin
                busy_r <= 1'b0;
                cnt_r  <= '0;
            end else begin
                cnt_r  <= cnt_r + CNT_ONE;
            end
        end else begin
            busy_r <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Handshaked WIDTH-bit ALU. One transaction at a time: accept in IDLE,
// optionally iterate in BUSY (multiply), hold result and flags in DONE until
// the consumer takes them.
// Build option: ALU_MUL_EN defined -> op 1000 is a WIDTH-cycle multiply;
//               undefined          -> op 1000 is illegal, no multiplier built.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready only in IDLE)
//   a, b, op            operands and operation code
//   out_valid/out_ready result handshake (out_valid only in DONE)
//   result              registered result
//   flag_z/c/v/n        zero, carry (ADD/SUB), signed overflow (ADD/SUB), MSB
//   mag                 two's complement magnitude of result for the display
//   err                 illegal or compiled-out op
// -----------------------------------------------------------------------------
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [ALU_OP_W-1:0] op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                flag_z,
    output logic                flag_c,
    output logic                flag_v,
    output logic                flag_n,
    output logic [WIDTH-1:0]    mag,
    output logic                err
);

    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_r, state_nxt_s;
    logic             accept_s, is_mul_s, mul_start_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s, alu_v_s, alu_err_s;
    logic             load_s;
    logic [WIDTH-1:0] fin_res_s;
    logic             fin_c_s, fin_v_s, fin_err_s;
    logic [WIDTH-1:0] result_r, mag_r;
    logic             flag_z_r, flag_c_r, flag_v_r, flag_n_r, err_r;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_prod_s;

    // The most negative value has no positive counterpart and maps to itself.
    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            mag_of = ~v + ONE_W;
        end else begin
            mag_of = v;
        end
    endfunction

    assign in_ready  = (state_r == S_IDLE);
    assign out_valid = (state_r == S_DONE);
    assign accept_s  = in_ready & in_valid;

`ifdef ALU_MUL_EN
    assign is_mul_s = (op == ALU_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start_s),
        .a       (a),
        .b       (b),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );
`else
    assign is_mul_s   = 1'b0;
    assign mul_done_s = 1'b0;
    assign mul_prod_s = '0;
`endif

    assign mul_start_s = accept_s & is_mul_s;

    // SUB shares the adder as a + ~b + 1 so carry-out means "no borrow".
    assign cin_s   = (op == ALU_SUB);
    assign b_eff_s = cin_s ? ~b : b;
    assign sum_s   = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};

    // Single-cycle operation decode straight from the live operands.
    always_comb begin
        alu_res_s = '0;
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        alu_err_s = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
                alu_v_s   = (a[WIDTH-1] == b_eff_s[WIDTH-1]) &&
                            (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_NOT: alu_res_s = ~a;
            ALU_AND: alu_res_s = a & b;
            ALU_OR:  alu_res_s = a | b;
            ALU_XOR: alu_res_s = a ^ b;
            ALU_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_EQ:  alu_res_s = {{(WIDTH-1){1'b0}}, (a == b)};
            // Illegal codes, and MUL when it is not built, land here.
            default: alu_err_s = 1'b1;
        endcase
    end

    // Pick what (if anything) loads the output registers this cycle.
    always_comb begin
        load_s    = 1'b0;
        fin_res_s = alu_res_s;
        fin_c_s   = alu_c_s;
        fin_v_s   = alu_v_s;
        fin_err_s = alu_err_s;
        if (accept_s && !is_mul_s) begin
            load_s = 1'b1;
        end else if ((state_r == S_BUSY) && mul_done_s) begin
            load_s    = 1'b1;
            fin_res_s = mul_prod_s;
            fin_c_s   = 1'b0;
            fin_v_s   = 1'b0;
            fin_err_s = 1'b0;
        end else begin
            load_s = 1'b0;
        end
    end

    // Next-state logic of the handshake FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = is_mul_s ? S_BUSY : S_DONE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (mul_done_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_BUSY;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DONE;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Result, flags and magnitude; held unchanged until the next transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= '0;
            mag_r    <= '0;
            flag_z_r <= 1'b0;
            flag_c_r <= 1'b0;
            flag_v_r <= 1'b0;
            flag_n_r <= 1'b0;
            err_r    <= 1'b0;
        end else if (load_s) begin
            result_r <= fin_res_s;
            mag_r    <= mag_of(fin_res_s);
            flag_z_r <= (fin_res_s == '0);
            flag_c_r <= fin_c_s;
            flag_v_r <= fin_v_s;
            flag_n_r <= fin_res_s[WIDTH-1];
            err_r    <= fin_err_s;
        end else begin
            result_r <= result_r;
        end
    end

    assign result = result_r;
    assign mag    = mag_r;
    assign flag_z = flag_z_r;
    assign flag_c = flag_c_r;
    assign flag_v = flag_v_r;
    assign flag_n = flag_n_r;
    assign err    = err_r;

endmodule
